// File: rtl/hwpe_job_sequencer_if.sv
// hwpe_job_sequencer_if: control-slave and streamer handshake bundle around the job sequencer
interface hwpe_job_sequencer_if #(
  parameter int unsigned NB_OPERANDS   = 2,
  parameter int unsigned NB_SINKS      = 1,
  parameter int unsigned ITER_WIDTH    = 16,
  parameter int unsigned TIMEOUT_WIDTH = 20
);
  logic                     clear;
  logic                     start;
  logic [ITER_WIDTH-1:0]    n_iter;
  logic [TIMEOUT_WIDTH-1:0] timeout;
  logic [NB_OPERANDS-1:0]   source_ready;
  logic [NB_OPERANDS-1:0]   source_done;
  logic [NB_OPERANDS-1:0]   source_req_start;
  logic [NB_SINKS-1:0]      sink_ready;
  logic [NB_SINKS-1:0]      sink_done;
  logic [NB_SINKS-1:0]      sink_req_start;
  logic                     done;
  logic                     busy;
  logic                     error;
  logic [ITER_WIDTH-1:0]    iter_cnt;
  modport master (
    input  clear, start, n_iter, timeout, source_ready, source_done, sink_ready, sink_done,
    output source_req_start, sink_req_start, done, busy, error, iter_cnt
  );
  modport slave (
    output clear, start, n_iter, timeout, source_ready, source_done, sink_ready, sink_done,
    input  source_req_start, sink_req_start, done, busy, error, iter_cnt
  );
endinterface

// File: rtl/hwpe_job_sequencer.sv
// hwpe_job_sequencer: runs n back-to-back streamer jobs per start pulse, each guarded by a watchdog
module hwpe_job_sequencer #(
  parameter int unsigned NB_OPERANDS   = 2,
  parameter int unsigned NB_SINKS      = 1,
  parameter int unsigned ITER_WIDTH    = 16,
  parameter int unsigned TIMEOUT_WIDTH = 20
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  hwpe_job_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, ARM, LAUNCH, RUN, NEXT, FINISH} state_e;
  state_e                   state_q, state_d;
  logic [ITER_WIDTH-1:0]    n_iter_q, iter_q;
  logic [TIMEOUT_WIDTH-1:0] timeout_q, wd_q;
  logic [NB_OPERANDS-1:0]   src_cap_q;
  logic [NB_SINKS-1:0]      snk_cap_q;
  logic                     req_q, done_q, error_q;
  logic                     all_done, wd_hit, last_job;
  always_comb begin
    all_done = &{src_cap_q | bus.source_done, snk_cap_q | bus.sink_done};
    wd_hit   = (timeout_q != '0) && (wd_q == timeout_q - TIMEOUT_WIDTH'(1));
    last_job = (iter_q + ITER_WIDTH'(1)) == n_iter_q;
    state_d  = state_q;
    unique case (state_q)
      IDLE:    state_d = !bus.start ? IDLE : (bus.n_iter == '0 ? FINISH : ARM);
      ARM:     state_d = &{bus.source_ready, bus.sink_ready} ? LAUNCH : ARM;
      LAUNCH:  state_d = RUN;
      RUN:     state_d = all_done ? NEXT : (wd_hit ? FINISH : RUN);
      NEXT:    state_d = last_job ? FINISH : ARM;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= bus.clear ? IDLE : state_d;
  // clear abandons the sequence silently: done_q is wiped along with everything else
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      n_iter_q  <= '0;
      timeout_q <= '0;
      iter_q    <= '0;
      wd_q      <= '0;
      src_cap_q <= '0;
      snk_cap_q <= '0;
      req_q     <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else if (bus.clear) begin
      n_iter_q  <= '0;
      timeout_q <= '0;
      iter_q    <= '0;
      wd_q      <= '0;
      src_cap_q <= '0;
      snk_cap_q <= '0;
      req_q     <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && bus.start) begin
        n_iter_q  <= bus.n_iter;
        timeout_q <= bus.timeout;
        iter_q    <= '0;
        error_q   <= 1'b0;
      end
      if (state_q == LAUNCH) begin
        src_cap_q <= '0;
        snk_cap_q <= '0;
        wd_q      <= '0;
      end
      if (state_q == RUN) begin
        src_cap_q <= src_cap_q | bus.source_done;
        snk_cap_q <= snk_cap_q | bus.sink_done;
        wd_q      <= &wd_q ? wd_q : wd_q + TIMEOUT_WIDTH'(1);
        if (!all_done && wd_hit) error_q <= 1'b1;
      end
      if (state_q == NEXT) iter_q <= iter_q + ITER_WIDTH'(1);
      req_q  <= state_d == LAUNCH;
      done_q <= state_q == FINISH;
    end
  assign bus.source_req_start = {NB_OPERANDS{req_q}};
  assign bus.sink_req_start   = {NB_SINKS{req_q}};
  assign bus.done             = done_q;
  assign bus.busy             = state_q != IDLE;
  assign bus.error            = error_q;
  assign bus.iter_cnt         = iter_q;
endmodule
